// File: rtl/mem_responder.sv
// mem_responder: word-wide instruction/data memory with a valid/ready request channel and a
// programmable number of wait states before a one-cycle response strobe.
//
// Parameters:
//   ADDR_W      request address width (bits); must exceed log2(DEPTH_WORDS)+2
//   DEPTH_WORDS number of 32-bit words (power of two)
//   WAIT_CYCLES wait states between accept and response (0..15)
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-high reset of control state (memory array untouched)
//   req_valid_i  request present
//   req_write_i  1 = write, 0 = read
//   req_addr_i   byte address
//   req_wdata_i  write data
//   req_be_i     write byte enables, bit i covers wdata[8i+7:8i]
//   req_ready_o  request can be accepted this cycle (IDLE only)
//   rsp_valid_o  one-cycle response strobe
//   rsp_rdata_o  read data; 0 for writes and errored requests; held between responses
//   rsp_err_o    request faulted (qualified by rsp_valid_o)
//
// Build option: define MEM_ERR_CHECK_EN to enable misalignment / out-of-range faults. Without it
// rsp_err_o is 0, addr[1:0] is ignored and the word index wraps modulo DEPTH_WORDS.
module mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_be_i,
  output logic              req_ready_o,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         mem_q [DEPTH_WORDS];

  logic                accept;
  logic                commit;
  logic                eff_write;
  logic [ADDR_W-1:0]   eff_addr;
  logic [31:0]         eff_wdata;
  logic [3:0]          eff_be;
  logic [IdxW-1:0]     eff_idx;
  logic                eff_err;

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the commit edge is also the accept edge, so the request must be taken
  // straight from the inputs rather than from the (not yet loaded) latches.
  always_comb begin
    if (state_q == StIdle) begin
      eff_write = req_write_i;
      eff_addr  = req_addr_i;
      eff_wdata = req_wdata_i;
      eff_be    = req_be_i;
    end else begin
      eff_write = write_q;
      eff_addr  = addr_q;
      eff_wdata = wdata_q;
      eff_be    = be_q;
    end
  end

  assign eff_idx = eff_addr[IdxW+1:2];

`ifdef MEM_ERR_CHECK_EN
  assign eff_err = (eff_addr[1:0] != 2'b00) || (eff_addr[ADDR_W-1:IdxW+2] != '0);
`else
  logic unused_addr;
  assign unused_addr = ^{eff_addr[ADDR_W-1:IdxW+2], eff_addr[1:0]};
  assign eff_err     = 1'b0;
`endif

  // Commit on the edge entering RESP; never while reset is asserted.
  assign commit = (state_d == StResp) && (state_q != StResp) && !rst_i;

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = eff_err;
      rdata_d = (eff_write || eff_err) ? 32'h0 : mem_q[eff_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        write_q <= req_write_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        be_q    <= req_be_i;
      end
    end
  end

  // Storage array is not reset.
  always_ff @(posedge clk_i) begin
    if (commit && eff_write && !eff_err) begin
      for (int b = 0; b < 4; b++) begin
        if (eff_be[b]) mem_q[eff_idx][8*b +: 8] <= eff_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  localparam int unsigned Wait = 2;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0 = 1'b0;
  logic        ready0, valid0, err0;
  logic [31:0] rdata0;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t sb_q[$];
  vec_t tbl[15];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder #(.ADDR_W(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(Wait)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_be_i(req_be),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err)
  );

  mem_responder #(.ADDR_W(32), .DEPTH_WORDS(16), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v0), .req_write_i(1'b1),
    .req_addr_i(32'h8), .req_wdata_i(32'h5A5A_0F0F), .req_be_i(4'hF),
    .req_ready_o(ready0), .rsp_valid_o(valid0), .rsp_rdata_o(rdata0),
    .rsp_err_o(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor for the main DUT.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_latency", cyc, e.due);
      end
    end
  end

  task automatic run_req(input vec_t v);
    bit got = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_be = v.be;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back('{rdata: v.rdata, err: v.err, due: cyc + Wait + 1});
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      chk("rsp_timeout", 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    tbl[4]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    tbl[5]  = '{1'b1, 32'h24,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 32'h24,   32'h12345678, 4'h0, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'h24,   32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    tbl[8]  = '{1'b1, 32'h0,    32'h0BADC0DE, 4'hF, 32'h0,        1'b0};
`ifdef MEM_ERR_CHECK_EN
    tbl[9]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'h0,        1'b1};
    tbl[10] = '{1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0,        1'b1};
    tbl[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h0BADC0DE, 1'b0};
    tbl[14] = '{1'b0, 32'h2,    32'h0,        4'h0, 32'h0,        1'b1};
`else
    tbl[9]  = '{1'b0, 32'h13,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    tbl[10] = '{1'b1, 32'h1000, 32'h77777777, 4'hF, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'h0,    32'h0,        4'h0, 32'h77777777, 1'b0};
    tbl[14] = '{1'b0, 32'h2,    32'h0,        4'h0, 32'h77777777, 1'b0};
`endif
    tbl[12] = '{1'b1, 32'hFFC,  32'h600DF00D, 4'hF, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 32'hFFC,  32'h0,        4'h0, 32'h600DF00D, 1'b0};

    // Reset held 3 cycles, then idle state.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);

    // Zero wait states with req_valid held high: accept every second cycle.
    @(posedge clk); #1 v0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("zw_ready", {31'd0, ready0}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("zw_valid", {31'd0, valid0}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("zw_err", {31'd0, err0}, 32'd0);
    end
    @(posedge clk); #1 v0 = 1'b0;

    for (int i = 0; i < 15; i++) run_req(tbl[i]);

    // Reset one cycle after accepting a write: no response, write discarded.
    run_req('{1'b1, 32'h40, 32'h01020304, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40;
    req_wdata = 32'h55AA55AA; req_be = 4'hF;
    @(negedge clk);
    chk("mid_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    chk("mid_rdata_clr", rsp_rdata, 32'h0);
    run_req('{1'b0, 32'h40, 32'h0, 4'h0, 32'h01020304, 1'b0});

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
